// File: rtl/md_unit_if.sv
// Operand, HI/LO-access and status bundle between the issuing pipeline
// stage and the multiply/divide unit.
interface md_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        hilo_we;
   logic        hilo_sel;
   logic [31:0] hilo_wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, operand_a, operand_b, hilo_we, hilo_sel, hilo_wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b, hilo_we, hilo_sel, hilo_wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Latency is set by a down-counter; results land on hi/lo only at done.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO writes honoured
// S_RUN  | operation in flight; counter runs down to terminal count 1
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     rst_n,
   md_unit_if.slave md
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             done_q, done_d;

   logic        is_div;
   logic        is_uns;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] mag_b_safe;
   logic [31:0] mag_q;
   logic [31:0] mag_r;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        div_zero;

   assign is_div = op_q[1];
   assign is_uns = op_q[0];

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
   // then correct for both signed and unsigned multiply.
   always_comb begin
      mul_a   = is_uns ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
      mul_b   = is_uns ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
      product = mul_a * mul_b;
   end

   // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly
   // instead of relying on signed-overflow behaviour of the divider.
   always_comb begin
      neg_a      = ~is_uns & a_q[31];
      neg_b      = ~is_uns & b_q[31];
      mag_a      = neg_a ? (~a_q + 32'd1) : a_q;
      mag_b      = neg_b ? (~b_q + 32'd1) : b_q;
      div_zero   = (b_q == 32'd0);
      mag_b_safe = div_zero ? 32'd1 : mag_b;
      mag_q      = mag_a / mag_b_safe;
      mag_r      = mag_a % mag_b_safe;
      quot       = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
      rem        = neg_a ? (~mag_r + 32'd1) : mag_r;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (md.hilo_we) begin
               if (md.hilo_sel) hi_d = md.hilo_wdata;
               else             lo_d = md.hilo_wdata;
            end
            if (md.start) begin
               op_d    = md.op;
               a_d     = md.operand_a;
               b_d     = md.operand_b;
               cnt_d   = md.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (!is_div) begin
                  hi_d = product[63:32];
                  lo_d = product[31:0];
               end else if (!div_zero) begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign md.busy = (state_q == S_RUN);
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, start/MTHI/MTLO interplay and
// async reset abort. Inputs change and outputs are sampled on the falling edge.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;

   md_unit_if md_if ();

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a falling edge; returns at the next falling edge with start low.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      md_if.start     = 1'b1;
      md_if.op        = op;
      md_if.operand_a = a;
      md_if.operand_b = b;
      @(negedge clk);
      md_if.start     = 1'b0;
   endtask

   // Counts falling edges with busy high; leaves us at the first idle one.
   task automatic wait_idle(output int n);
      n = 0;
      while (md_if.busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      md_if.start = 1'b0; md_if.op = 2'b00;
      md_if.operand_a = 32'd0; md_if.operand_b = 32'd0;
      md_if.hilo_we = 1'b0; md_if.hilo_sel = 1'b0; md_if.hilo_wdata = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.busy !== 1'b0 || md_if.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all zero",
                  md_if.hi, md_if.lo, md_if.busy, md_if.done);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      int n;
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      checks++;
      if (n !== MC) begin fails++; $display("FAIL mult_latency: busy %0d cycles, want %0d", n, MC); end
      checks++;
      if (md_if.done !== 1'b1) begin fails++; $display("FAIL mult_done: done=%b, want 1", md_if.done); end
      checks++;
      if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFA) begin
         fails++;
         $display("FAIL mult_result: hi=%h lo=%h, want FFFFFFFF FFFFFFFA", md_if.hi, md_if.lo);
      end
      @(negedge clk);
      checks++;
      if (md_if.done !== 1'b0) begin fails++; $display("FAIL done_width: done=%b one cycle later, want 0", md_if.done); end
   endtask

   task automatic test_multu();
      int n;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++;
      if (n !== MC || md_if.hi !== 32'hFFFF_FFFE || md_if.lo !== 32'h0000_0001) begin
         fails++;
         $display("FAIL multu: cycles=%0d hi=%h lo=%h, want %0d FFFFFFFE 00000001", n, md_if.hi, md_if.lo, MC);
      end
      @(negedge clk);
   endtask

   task automatic test_div();
      int n;
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      checks++;
      if (n !== DC) begin fails++; $display("FAIL div_latency: busy %0d cycles, want %0d", n, DC); end
      checks++;
      if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFD || md_if.done !== 1'b1) begin
         fails++;
         $display("FAIL div_neg: hi=%h lo=%h done=%b, want FFFFFFFF FFFFFFFD 1", md_if.hi, md_if.lo, md_if.done);
      end
      @(negedge clk);

      issue(OP_DIVU, 32'd7, 32'd0);
      wait_idle(n);
      checks++;
      if (n !== DC || md_if.done !== 1'b1) begin
         fails++;
         $display("FAIL divu_zero_timing: cycles=%0d done=%b, want %0d 1", n, md_if.done, DC);
      end
      checks++;
      if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFD) begin
         fails++;
         $display("FAIL divu_zero_hold: hi=%h lo=%h, want FFFFFFFF FFFFFFFD", md_if.hi, md_if.lo);
      end
      @(negedge clk);

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++;
      if (md_if.hi !== 32'd0 || md_if.lo !== 32'h8000_0000) begin
         fails++;
         $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", md_if.hi, md_if.lo);
      end
      @(negedge clk);

      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      wait_idle(n);
      checks++;
      if (md_if.hi !== 32'd1 || md_if.lo !== 32'hFFFF_FFFD) begin
         fails++;
         $display("FAIL div_neg_divisor: hi=%h lo=%h, want 00000001 FFFFFFFD", md_if.hi, md_if.lo);
      end
      @(negedge clk);

      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
      wait_idle(n);
      checks++;
      if (md_if.hi !== 32'h0000_000F || md_if.lo !== 32'h0FFF_FFFF) begin
         fails++;
         $display("FAIL divu: hi=%h lo=%h, want 0000000F 0FFFFFFF", md_if.hi, md_if.lo);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n;
      issue(OP_MULT, 32'd3, 32'd4);
      md_if.start     = 1'b1;
      md_if.op        = OP_DIVU;
      md_if.operand_a = 32'd100;
      md_if.operand_b = 32'd7;
      @(negedge clk);
      md_if.start     = 1'b0;
      wait_idle(n);
      checks++;
      if (n !== MC - 1) begin fails++; $display("FAIL ignore_start_latency: %0d more busy cycles, want %0d", n, MC - 1); end
      checks++;
      if (md_if.hi !== 32'd0 || md_if.lo !== 32'd12 || md_if.done !== 1'b1) begin
         fails++;
         $display("FAIL ignore_start_result: hi=%h lo=%h done=%b, want 0 0000000C 1", md_if.hi, md_if.lo, md_if.done);
      end
      issue(OP_MULTU, 32'd5, 32'd6);
      checks++;
      if (md_if.busy !== 1'b1) begin fails++; $display("FAIL back_to_back_accept: busy=%b, want 1", md_if.busy); end
      wait_idle(n);
      checks++;
      if (n !== MC || md_if.hi !== 32'd0 || md_if.lo !== 32'd30) begin
         fails++;
         $display("FAIL back_to_back_result: cycles=%0d hi=%h lo=%h, want %0d 0 0000001E", n, md_if.hi, md_if.lo, MC);
      end
      @(negedge clk);
   endtask

   task automatic test_hilo_write();
      int n;
      md_if.hilo_we = 1'b1; md_if.hilo_sel = 1'b1; md_if.hilo_wdata = 32'hAAAA_5555;
      @(negedge clk);
      md_if.hilo_sel = 1'b0; md_if.hilo_wdata = 32'h0000_1234;
      @(negedge clk);
      md_if.hilo_we = 1'b0;
      checks++;
      if (md_if.hi !== 32'hAAAA_5555 || md_if.lo !== 32'h0000_1234) begin
         fails++;
         $display("FAIL mthi_mtlo_idle: hi=%h lo=%h, want AAAA5555 00001234", md_if.hi, md_if.lo);
      end

      issue(OP_MULT, 32'd2, 32'd3);
      md_if.hilo_we = 1'b1; md_if.hilo_sel = 1'b1; md_if.hilo_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      md_if.hilo_we = 1'b0;
      checks++;
      if (md_if.hi !== 32'hAAAA_5555 || md_if.lo !== 32'h0000_1234) begin
         fails++;
         $display("FAIL mthi_while_busy: hi=%h lo=%h, want AAAA5555 00001234", md_if.hi, md_if.lo);
      end
      wait_idle(n);
      checks++;
      if (md_if.hi !== 32'd0 || md_if.lo !== 32'd6) begin
         fails++;
         $display("FAIL mult_after_busy_write: hi=%h lo=%h, want 0 00000006", md_if.hi, md_if.lo);
      end
      @(negedge clk);

      md_if.hilo_we = 1'b1; md_if.hilo_sel = 1'b1; md_if.hilo_wdata = 32'hCAFE_F00D;
      issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      md_if.hilo_we = 1'b0;
      checks++;
      if (md_if.busy !== 1'b1 || md_if.hi !== 32'hCAFE_F00D || md_if.lo !== 32'd6) begin
         fails++;
         $display("FAIL start_with_mthi: busy=%b hi=%h lo=%h, want 1 CAFEF00D 00000006", md_if.busy, md_if.hi, md_if.lo);
      end
      wait_idle(n);
      checks++;
      if (md_if.hi !== 32'd0 || md_if.lo !== 32'd1) begin
         fails++;
         $display("FAIL start_with_mthi_result: hi=%h lo=%h, want 0 00000001", md_if.hi, md_if.lo);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int saw_done;
      md_if.hilo_we = 1'b1; md_if.hilo_sel = 1'b1; md_if.hilo_wdata = 32'h0000_0055;
      @(negedge clk);
      md_if.hilo_we = 1'b0;
      issue(OP_DIV, 32'd100, 32'd3);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.busy !== 1'b0 || md_if.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_abort: hi=%h lo=%h busy=%b done=%b, want all zero",
                  md_if.hi, md_if.lo, md_if.busy, md_if.done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < DC + 4; i++) begin
         @(negedge clk);
         if (md_if.done === 1'b1 || md_if.busy === 1'b1) saw_done++;
      end
      checks++;
      if (saw_done !== 0 || md_if.lo !== 32'd0 || md_if.hi !== 32'd0) begin
         fails++;
         $display("FAIL reset_no_result: activity=%0d hi=%h lo=%h, want 0 0 0", saw_done, md_if.hi, md_if.lo);
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_back_to_back();
      test_hilo_write();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
